scrambler_checker_param: RTL
============================

Name: scrambler_checker_param

Overview:
- Parametrised successor to the fixed six-channel, 3-bit scrambler/checker.
- Captures NCH channels of W bits on a ready strobe and applies one of four selectable scramble transforms. It also checks sequentially, one channel per cycle, that the captured input is a valid permutation of 0..NCH-1.
- Presents the result with a one-cycle done pulse and keeps a saturating error count.
- Sits between the puzzle-state generator and the display/compare logic.

Parameters:
- NCH, 6, number of channels (2..16).
- W, 3, bits per channel (1..8; 2^W >= NCH).
- RW, 3, width of rot port; must be >= clog2(NCH).
- SEED, 8'hA5, LFSR reset value (nonzero).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- ready  in  1  start request, sampled only in IDLE
- mode  in  2  transform select, sampled with ready: 00 pass, 01 rotate, 10 LFSR-xor, 11 reverse
- rot  in  RW  rotate amount, sampled with ready; used mod NCH
- din  in  NCH*W  input channels; channel j = din[j*W +: W]
- busy  out  1  high from the capture edge until the DONE edge
- done  out  1  one-cycle pulse when dout/valid_perm update
- dout  out  NCH*W  scrambled channels, same packing as din
- valid_perm  out  1  1 = captured input was a permutation of 0..NCH-1
- err_count  out  8  count of failed checks, saturates at 255

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, dout=0, valid_perm=0, err_count=0; lfsr=SEED; seen=0, bad=0, idx=0. Reset mid-operation aborts it: no done pulse, and nothing is committed.
- State machine: IDLE -> SCRAMBLE -> CHECK (NCH cycles) -> DONE -> IDLE.
- IDLE:
  - done=0.
  - If ready=1 at an edge (E0): capture din into orig and buf, latch mode_r and rot_r=rot mod NCH, set busy=1, go to SCRAMBLE.
- SCRAMBLE (edge E1):
  - 00: buf unchanged.
  - 01: out[j]=orig[(j+rot_r) mod NCH].
  - 10: out[j]=orig[j] XOR ((lfsr[W-1:0]+j) mod 2^W), using the pre-advance lfsr. lfsr then advances one step: shift left, bit0 = l7^l5^l4^l3.
  - 11: out[j]=orig[NCH-1-j].
  - The LFSR advances only in mode 10.
  - Clear seen, bad and idx; go to CHECK.
- CHECK (edges E2..E(NCH+1)):
  - v=orig[idx].
  - If v>=NCH or seen[v]=1, set bad=1; otherwise set seen[v]=1.
  - idx++. After idx=NCH-1, go to DONE.
  - The check always uses the original input, never the scrambled data.
- DONE (edge E(NCH+2)):
  - dout<=buf; valid_perm<=~bad; done<=1; busy<=0.
  - If bad, err_count<=min(err_count+1, 255).
  - Go to IDLE.
- Timing:
  - done is high for exactly the one cycle after E(NCH+2), i.e. latency NCH+2 edges from the ready-sampling edge.
  - done drops at the next edge even if a new op starts on that edge.
  - With ready held high, one op starts every NCH+3 edges.
- ready while busy: ignored, not queued. din, mode and rot may change freely after E0.
- dout and valid_perm hold their values between DONE edges.

Test Plan (NCH=6, W=3, SEED=8'hA5; din listed as ch0..ch5):
1. mode=00, din=0,1,2,3,4,5, ready pulsed one cycle -> busy high for 8 edges; done pulse after the 8th edge; dout=0,1,2,3,4,5; valid_perm=1; err_count=0.
2. mode=01, rot=2, din=0..5 -> dout=2,3,4,5,0,1, valid_perm=1. Then rot=7 (mod 6 = 1) -> dout=1,2,3,4,5,0.
3. mode=00, din=0,1,1,3,4,5 -> valid_perm=0, err_count=1. Then din=0,1,2,3,4,6 -> valid_perm=0, err_count=2. Then 256 further bad ops -> err_count stays 255.
4. mode=10, din all 0 -> key=5, dout=5,6,7,0,1,2, valid_perm=0; lfsr becomes 8'h4A. Repeating the op -> key=2, dout=2,3,4,5,6,7.
5. Pulse ready again during CHECK -> ignored, exactly one done. Assert rst mid-CHECK -> done never pulses; dout=0, busy=0, lfsr=8'hA5. Next mode-10 op reproduces scenario 4's first result.
6. ready held high, mode=11, din=0..5 -> done pulses every 9 edges; dout=5,4,3,2,1,0; valid_perm=1.

Source files
------------

// File: rtl/scrambler_checker_param.sv
// rtl/scrambler_checker_param.sv - NCH-channel scrambler with sequential permutation checker
module scrambler_checker_param #(
    parameter int          NCH  = 6,
    parameter int          W    = 3,
    parameter int          RW   = 3,
    parameter logic [7:0]  SEED = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic [1:0]       mode,
    input  logic [RW-1:0]    rot,
    input  logic [NCH*W-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [NCH*W-1:0] dout,
    output logic             valid_perm,
    output logic [7:0]       err_count
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCRAMBLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [NCH*W-1:0] orig;
    logic [NCH*W-1:0] buf_r;
    logic [NCH*W-1:0] scr;
    logic [1:0]       mode_r;
    logic [IW-1:0]    rot_r;
    logic [IW-1:0]    rot_mod;
    logic [7:0]       lfsr;
    logic [7:0]       lfsr_next;
    logic [NCH-1:0]   seen;
    logic             bad;
    logic [IW-1:0]    idx;

    logic [W-1:0]     v;
    logic [NCH-1:0]   v_oh;
    logic             v_in_range;
    logic             v_dup;
    logic             idx_last;

    // Reduce the requested rotation modulo the channel count at capture time
    always_comb begin
        rot_mod = IW'(32'(rot) % NCH);
    end

    // Fibonacci LFSR step: shift left, feedback from taps 7,5,4,3
    always_comb begin
        lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    // Build the scrambled channel vector from the captured original
    always_comb begin
        scr = buf_r;
        case (mode_r)
            2'b01: begin
                for (int j = 0; j < NCH; j++) begin
                    scr[j*W +: W] = orig[((j + int'(rot_r)) % NCH)*W +: W];
                end
            end
            2'b10: begin
                for (int j = 0; j < NCH; j++) begin
                    scr[j*W +: W] = orig[j*W +: W] ^ (lfsr[W-1:0] + W'(j));
                end
            end
            2'b11: begin
                for (int j = 0; j < NCH; j++) begin
                    scr[j*W +: W] = orig[(NCH-1-j)*W +: W];
                end
            end
            default: scr = buf_r;
        endcase
    end

    // Examine one original channel per cycle for range and duplicates
    always_comb begin
        v          = orig[int'(idx)*W +: W];
        v_oh       = NCH'(1) << v;
        v_in_range = (32'(v) < NCH);
        v_dup      = |(seen & v_oh);
        idx_last   = (idx == IW'(NCH-1));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state sequencing IDLE -> SCRAMBLE -> CHECK x NCH -> DONE
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (ready) state_nx = S_SCRAMBLE;
            S_SCRAMBLE: state_nx = S_CHECK;
            S_CHECK:    if (idx_last) state_nx = S_DONE;
            S_DONE:     state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Datapath: capture, scramble, check and commit results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            dout       <= '0;
            valid_perm <= 1'b0;
            err_count  <= 8'd0;
            lfsr       <= SEED;
            seen       <= '0;
            bad        <= 1'b0;
            idx        <= '0;
            orig       <= '0;
            buf_r      <= '0;
            mode_r     <= 2'b00;
            rot_r      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ready) begin
                        orig   <= din;
                        buf_r  <= din;
                        mode_r <= mode;
                        rot_r  <= rot_mod;
                        busy   <= 1'b1;
                    end
                end
                S_SCRAMBLE: begin
                    buf_r <= scr;
                    if (mode_r == 2'b10) begin
                        lfsr <= lfsr_next;
                    end
                    seen <= '0;
                    bad  <= 1'b0;
                    idx  <= '0;
                end
                S_CHECK: begin
                    if (!v_in_range || v_dup) begin
                        bad <= 1'b1;
                    end else begin
                        seen <= seen | v_oh;
                    end
                    idx <= idx + IW'(1);
                end
                S_DONE: begin
                    dout       <= buf_r;
                    valid_perm <= ~bad;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    if (bad && (err_count != 8'hFF)) begin
                        err_count <= err_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
